// File: rtl/input_feeder.sv
// Purpose : buffers one INPUT_HEIGHT x INPUT_WIDTH tile of pixel vectors and serves them in raster order.
// Latency : input_req sampled high in SERVE_WAIT gives input_ready/input_val one cycle later; serves are at least 3 cycles apart.
// Backpres: load_ready is high only while loading, so upstream holds data otherwise. input_req is a level that the requester holds until served.
// Ports   : clock/reset (sync, active-high); load_valid/load_data/load_ready (tile fill stream);
//           input_req/input_ready/input_val/width_index/height_index (pixel serve handshake); tile_done (end-of-tile pulse).
module input_feeder #(
  parameter int BIN_LEN       = 8,
  parameter int INPUT_CHANNEL = 4,
  parameter int INPUT_HEIGHT  = 8,
  parameter int INPUT_WIDTH   = 8,
  localparam int DW = INPUT_CHANNEL * BIN_LEN,
  localparam int WW = (INPUT_WIDTH  > 1) ? $clog2(INPUT_WIDTH)  : 1,
  localparam int HW = (INPUT_HEIGHT > 1) ? $clog2(INPUT_HEIGHT) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  output logic          load_ready,
  input  logic          input_req,
  output logic          input_ready,
  output logic [DW-1:0] input_val,
  output logic [WW-1:0] width_index,
  output logic [HW-1:0] height_index,
  output logic          tile_done
);

  localparam int N  = INPUT_HEIGHT * INPUT_WIDTH;
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_LOAD,
    S_SERVE_WAIT,
    S_SERVE_ACK,
    S_SERVE_GAP,
    S_DONE
  } state_t;

  state_t        state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  // Row/column of rd_ptr kept as separate counters so non-power-of-two widths need no divider.
  logic [WW-1:0] rd_col;
  logic [HW-1:0] rd_row;
  logic [DW-1:0] mem [N];
  logic          wr_en;

  // Reset blocks the write so a beat presented during reset is dropped.
  assign wr_en = (state == S_LOAD) && load_valid && !reset;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= load_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_LOAD;
      load_ready   <= 1'b1;
      input_ready  <= 1'b0;
      tile_done    <= 1'b0;
      input_val    <= '0;
      width_index  <= '0;
      height_index <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      rd_col       <= '0;
      rd_row       <= '0;
    end else begin
      input_ready <= 1'b0;
      tile_done   <= 1'b0;
      case (state)
        S_LOAD: begin
          if (load_valid) begin
            wr_ptr <= wr_ptr + PW'(1);
            if (wr_ptr == PW'(N - 1)) begin
              state      <= S_SERVE_WAIT;
              load_ready <= 1'b0;
              rd_ptr     <= '0;
              rd_col     <= '0;
              rd_row     <= '0;
            end
          end
        end
        S_SERVE_WAIT: begin
          if (input_req) begin
            input_val    <= mem[rd_ptr];
            width_index  <= rd_col;
            height_index <= rd_row;
            input_ready  <= 1'b1;
            state        <= S_SERVE_ACK;
          end
        end
        S_SERVE_ACK: begin
          if (rd_ptr == PW'(N - 1)) begin
            tile_done <= 1'b1;
            state     <= S_DONE;
          end else begin
            rd_ptr <= rd_ptr + PW'(1);
            if (rd_col == WW'(INPUT_WIDTH - 1)) begin
              rd_col <= '0;
              rd_row <= rd_row + HW'(1);
            end else begin
              rd_col <= rd_col + WW'(1);
            end
            state <= S_SERVE_GAP;
          end
        end
        // Lets the requester drop a still-high input_req before it could be served twice.
        S_SERVE_GAP: begin
          state <= S_SERVE_WAIT;
        end
        S_DONE: begin
          wr_ptr     <= '0;
          rd_ptr     <= '0;
          rd_col     <= '0;
          rd_row     <= '0;
          load_ready <= 1'b1;
          state      <= S_LOAD;
        end
        default: begin
          load_ready <= 1'b1;
          state      <= S_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_feeder.sv
// Testbench for input_feeder: random and directed tiles against a pixel-queue model of the serve protocol.
// The model tracks loaded pixels in a queue, serve spacing as a countdown, and end-of-tile as a short post sequence.
module tb_input_feeder;

  localparam int BL = 8;
  localparam int CH = 4;
  localparam int H  = 8;
  localparam int W  = 8;
  localparam int DW = BL * CH;
  localparam int N  = H * W;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          load_ready;
  logic          input_req = 1'b0;
  logic          input_ready;
  logic [DW-1:0] input_val;
  logic [2:0]    width_index;
  logic [2:0]    height_index;
  logic          tile_done;

  input_feeder #(
    .BIN_LEN(BL), .INPUT_CHANNEL(CH), .INPUT_HEIGHT(H), .INPUT_WIDTH(W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .load_valid(load_valid),
    .load_data(load_data),
    .load_ready(load_ready),
    .input_req(input_req),
    .input_ready(input_ready),
    .input_val(input_val),
    .width_index(width_index),
    .height_index(height_index),
    .tile_done(tile_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic          m_lrdy;
  int            m_elig;
  int            m_post;
  int            m_served;
  int            m_done = 0;
  int            done_seen = 0;
  logic [DW-1:0] m_val;
  int            m_w;
  int            m_h;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int mode, input int p);
    logic [BL-1:0] v;
    case (mode)
      0:       v = BL'(p);
      1:       v = BL'(200 - p);
      2:       v = BL'(100 + p);
      default: return $urandom;
    endcase
    return {CH{v}};
  endfunction

  // One clock: drive inputs at the falling edge, predict, then check outputs at the next falling edge.
  task automatic step(input logic lv, input logic [DW-1:0] ld, input logic rq);
    logic e_rdy, e_done, nxt_lrdy;
    load_valid = lv;
    load_data  = ld;
    input_req  = rq;
    check("load_ready", load_ready, m_lrdy);
    e_rdy = 1'b0;
    e_done = 1'b0;
    nxt_lrdy = m_lrdy;
    if (m_lrdy) begin
      if (lv) begin
        mq.push_back(ld);
        if (mq.size() == N) begin
          nxt_lrdy = 1'b0;
          m_elig = 0;
          m_served = 0;
        end
      end
    end else if (m_post == 2) begin
      e_done = 1'b1;
      m_done++;
      m_post = 1;
    end else if (m_post == 1) begin
      nxt_lrdy = 1'b1;
      m_post = 0;
    end else if (m_elig > 0) begin
      m_elig--;
    end else if (rq) begin
      e_rdy = 1'b1;
      m_val = mq.pop_front();
      m_w = m_served % W;
      m_h = m_served / W;
      m_served++;
      m_elig = 2;
      if (m_served == N) m_post = 2;
    end
    m_lrdy = nxt_lrdy;
    @(negedge clock);
    check("input_ready", input_ready, e_rdy);
    check("tile_done", tile_done, e_done);
    check("input_val", input_val, m_val);
    check("width_index", width_index, m_w);
    check("height_index", height_index, m_h);
    if (tile_done === 1'b1) done_seen++;
  endtask

  // Reset for one clock with a load beat presented, which must not be written.
  task automatic do_reset();
    reset = 1'b1;
    load_valid = 1'b1;
    load_data = $urandom;
    input_req = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    mq.delete();
    m_lrdy = 1'b1;
    m_post = 0;
    m_served = 0;
    m_elig = 0;
    m_val = '0;
    m_w = 0;
    m_h = 0;
    check("rst_load_ready", load_ready, 1);
    check("rst_input_ready", input_ready, 0);
    check("rst_tile_done", tile_done, 0);
    check("rst_input_val", input_val, 0);
    check("rst_width_index", width_index, 0);
    check("rst_height_index", height_index, 0);
  endtask

  // vmode: 0 continuous valid, 1 valid toggling each cycle (req pulsed in gaps), 2 random valid.
  task automatic load_phase(input int mode, input int vmode);
    int cyc;
    logic lv;
    logic rq;
    cyc = 0;
    while (m_lrdy && cyc < 1000) begin
      case (vmode)
        0:       lv = 1'b1;
        1:       lv = (cyc % 2 == 1);
        default: lv = 1'($urandom_range(0, 1));
      endcase
      rq = (vmode == 1) ? !lv : 1'($urandom_range(0, 1));
      step(lv, lv ? pix(mode, mq.size()) : DW'($urandom), rq);
      cyc++;
    end
    check("load_timeout", cyc < 1000, 1);
    if (vmode == 1) check("toggle_load_cycles", cyc, 128);
  endtask

  // rmode: 0 req held, 1 requester drops after ready, 2 sparse single-cycle pulses, 3 random.
  task automatic serve_phase(input int rmode, input int stop_at);
    int guard;
    int since;
    logic rq;
    guard = 0;
    since = 99;
    while (!m_lrdy && (stop_at == 0 || m_served < stop_at) && guard < 2000) begin
      case (rmode)
        0:       rq = 1'b1;
        1:       rq = !(since == 1 || since == 2);
        2:       rq = ($urandom_range(0, 3) == 0);
        default: rq = 1'($urandom_range(0, 1));
      endcase
      step(1'($urandom_range(0, 1)), $urandom, rq);
      since++;
      if (input_ready === 1'b1) since = 0;
      guard++;
    end
    check("serve_timeout", guard < 2000, 1);
  endtask

  initial begin
    do_reset();
    do_reset();
    // Ramp tile, input_req held high.
    load_phase(0, 0);
    serve_phase(0, 0);
    // Back-to-back second tile 200-p, toggling valid, requester-style req.
    load_phase(1, 1);
    serve_phase(1, 0);
    check("two_tiles_done", done_seen, 2);
    // Ramp tile with sparse single-cycle requests, reset after the 10th serve.
    load_phase(0, 2);
    serve_phase(2, 10);
    do_reset();
    // Fresh ramp 100+p from pixel 0, then a fully random tile.
    load_phase(2, 2);
    serve_phase(3, 0);
    load_phase(3, 2);
    serve_phase(3, 0);
    check("tile_done_total", done_seen, m_done);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
